mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single shared memory port.
// Ties alternate by last grant; a stuck memory leaves a sticky error that only reset clears.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t            state, state_nx;
  logic              last_d;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              arb_en, arb_i, arb_d;
  logic              grant_i, grant_d;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      last_d    <= 1'b0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else begin
      if (grant_d) begin
        last_d    <= 1'b1;
        lat_addr  <= d_addr;
        lat_we    <= d_we;
        lat_wdata <= d_wdata;
      end else if (grant_i) begin
        last_d    <= 1'b0;
        lat_addr  <= if_addr;
        lat_we    <= 1'b0;
        lat_wdata <= '0;
      end
      if (grant_i || grant_d)
        cnt <= '0;
      else if ((state == BUSY_I || state == BUSY_D) && !mem_ack && cnt != TO)
        cnt <= cnt + 8'd1;
    end
  end

  // The completing requester is masked so the other side gets the back-to-back slot.
  always_comb begin
    state_nx = state;
    arb_en   = 1'b0;
    arb_i    = if_req;
    arb_d    = d_req;
    case (state)
      IDLE: arb_en = 1'b1;
      BUSY_I: begin
        if (mem_ack) begin
          arb_en = 1'b1;
          arb_i  = 1'b0;
        end else if (cnt == TO) begin
          state_nx = ERR;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          arb_en = 1'b1;
          arb_d  = 1'b0;
        end else if (cnt == TO) begin
          state_nx = ERR;
        end
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
    grant_d = arb_en & arb_d & (~arb_i | ~last_d);
    grant_i = arb_en & arb_i & ~grant_d;
    if (arb_en)
      state_nx = grant_d ? BUSY_D : (grant_i ? BUSY_I : IDLE);
  end

  always_comb begin
    mem_req   = (state == BUSY_I) || (state == BUSY_D);
    mem_we    = (state == BUSY_D) && lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    if_ack    = (state == BUSY_I) && mem_ack;
    d_ack     = (state == BUSY_D) && mem_ack;
    if_rdata  = if_ack ? mem_rdata : '0;
    d_rdata   = d_ack ? mem_rdata : '0;
    err       = (state == ERR);
    stall     = (if_req & ~if_ack) | (d_req & ~d_ack) | err;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TOUT = 15;

  logic        CLOCK = 1'b0;
  logic        RST_n;
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack, stall, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TOUT)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .err(err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory port (0 none, 1 fetch, 2 data, 3 error),
  // who won last, how long the current owner has waited, and the captured request.
  int          m_owner, m_last, m_wait;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_wait = 0;
    m_addr = 0; m_wdata = 0; m_we = 1'b0;
  endtask

  function automatic int choose(input logic wi, input logic wd, input int last);
    if (wi && wd) return (last == 1) ? 2 : 1;
    if (wd)       return 2;
    if (wi)       return 1;
    return 0;
  endfunction

  task automatic model_edge();
    int winner;
    winner = -1;
    if (m_owner == 0) begin
      winner = choose(if_req, d_req, m_last);
    end else if (m_owner == 1 || m_owner == 2) begin
      if (mem_ack)
        winner = choose(m_owner == 1 ? 1'b0 : if_req, m_owner == 2 ? 1'b0 : d_req, m_last);
      else if (m_wait == TOUT)
        m_owner = 3;
      else
        m_wait++;
    end
    if (winner == 0) m_owner = 0;
    if (winner > 0) begin
      m_owner = winner; m_last = winner; m_wait = 0;
      m_addr  = (winner == 2) ? d_addr : if_addr;
      m_we    = (winner == 2) ? d_we : 1'b0;
      m_wdata = (winner == 2) ? d_wdata : 32'h0;
    end
  endtask

  task automatic model_check();
    logic ia, da, er;
    ia = (m_owner == 1) && mem_ack;
    da = (m_owner == 2) && mem_ack;
    er = (m_owner == 3);
    chk1 ("rnd mem_req",   mem_req,   (m_owner == 1) || (m_owner == 2));
    chk1 ("rnd mem_we",    mem_we,    (m_owner == 2) && m_we);
    chk32("rnd mem_addr",  mem_addr,  m_addr);
    chk32("rnd mem_wdata", mem_wdata, m_wdata);
    chk1 ("rnd if_ack",    if_ack,    ia);
    chk1 ("rnd d_ack",     d_ack,     da);
    chk32("rnd if_rdata",  if_rdata,  ia ? mem_rdata : 32'h0);
    chk32("rnd d_rdata",   d_rdata,   da ? mem_rdata : 32'h0);
    chk1 ("rnd err",       err,       er);
    chk1 ("rnd stall",     stall,     (if_req && !ia) || (d_req && !da) || er);
  endtask

  task automatic zero_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RST_n = 1'b0;
    zero_inputs();
    @(posedge CLOCK);
    @(negedge CLOCK);
    RST_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        ir, dr, we, ack;
    logic        e_req, e_we, e_iack, e_dack, e_stall;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[11];

  localparam logic [31:0] RD = 32'h0050_0093;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1, 32'h100};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 32'h10};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'h10};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h10};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'h10};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b1, 32'h100};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1, 32'h10};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 32'h100};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100};

    RST_n = 1'b0;
    zero_inputs();
    #1;
    chk1("reset mem_req", mem_req, 1'b0);
    chk1("reset err", err, 1'b0);
    chk1("reset stall", stall, 1'b0);
    chk32("reset mem_addr", mem_addr, 32'h0);
    do_reset();

    // Vector table: tie-break alternation and back-to-back handover.
    for (int i = 0; i < 11; i++) begin
      @(negedge CLOCK);
      if_req = tbl[i].ir; d_req = tbl[i].dr; d_we = tbl[i].we; mem_ack = tbl[i].ack;
      if_addr = 32'h10; d_addr = 32'h100; d_wdata = 32'h55; mem_rdata = RD;
      #1;
      chk1 ("tbl mem_req",  mem_req,  tbl[i].e_req);
      chk1 ("tbl mem_we",   mem_we,   tbl[i].e_we);
      chk1 ("tbl if_ack",   if_ack,   tbl[i].e_iack);
      chk1 ("tbl d_ack",    d_ack,    tbl[i].e_dack);
      chk1 ("tbl stall",    stall,    tbl[i].e_stall);
      chk32("tbl mem_addr", mem_addr, tbl[i].e_addr);
      chk32("tbl if_rdata", if_rdata, tbl[i].e_iack ? RD : 32'h0);
      chk32("tbl d_rdata",  d_rdata,  tbl[i].e_dack ? RD : 32'h0);
    end

    // Single-cycle fetch.
    do_reset();
    @(negedge CLOCK); if_req = 1; if_addr = 32'h10;
    #1 chk1("fetch pre-grant mem_req", mem_req, 1'b0);
    @(negedge CLOCK); mem_ack = 1; mem_rdata = RD;
    #1;
    chk32("fetch mem_addr", mem_addr, 32'h10);
    chk1 ("fetch if_ack", if_ack, 1'b1);
    chk32("fetch if_rdata", if_rdata, RD);
    @(negedge CLOCK); if_req = 0; mem_ack = 0;
    #1 chk1("fetch back to idle", mem_req, 1'b0);

    // Store with three wait cycles; request fields change after grant.
    do_reset();
    @(negedge CLOCK); d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK);
      d_addr = 32'h999; d_wdata = 32'h0; d_we = 0; mem_ack = (k == 3);
      #1;
      chk1 ("store mem_we", mem_we, 1'b1);
      chk32("store mem_addr", mem_addr, 32'h20);
      chk32("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1 ("store d_ack", d_ack, k == 3);
      chk1 ("store stall", stall, k != 3);
    end
    @(negedge CLOCK); d_req = 0; mem_ack = 0;
    #1 chk1("store done", mem_req, 1'b0);

    // Memory never answers: sixteen busy cycles, then sticky error.
    do_reset();
    @(negedge CLOCK); if_req = 1; if_addr = 32'h30;
    for (int k = 0; k <= TOUT; k++) begin
      @(negedge CLOCK);
      #1;
      chk1("timeout busy mem_req", mem_req, 1'b1);
      chk1("timeout busy err", err, 1'b0);
    end
    @(negedge CLOCK); mem_ack = 1;
    #1;
    chk1("timeout err", err, 1'b1);
    chk1("timeout mem_req", mem_req, 1'b0);
    chk1("timeout if_ack", if_ack, 1'b0);
    chk1("timeout stall", stall, 1'b1);
    @(negedge CLOCK); if_req = 0; mem_ack = 0;
    repeat (3) @(negedge CLOCK);
    #1;
    chk1("timeout sticky err", err, 1'b1);
    chk1("timeout sticky stall", stall, 1'b1);

    // Reset in the middle of a data transaction.
    do_reset();
    @(negedge CLOCK); d_req = 1; d_addr = 32'h40;
    @(negedge CLOCK);
    #1 chk1("midreset busy", mem_req, 1'b1);
    #1 RST_n = 0; mem_ack = 1; mem_rdata = 32'h77;
    #1;
    chk1 ("midreset mem_req", mem_req, 1'b0);
    chk1 ("midreset d_ack", d_ack, 1'b0);
    chk32("midreset d_rdata", d_rdata, 32'h0);
    chk32("midreset mem_addr", mem_addr, 32'h0);
    @(negedge CLOCK); RST_n = 1; mem_ack = 0;
    #1 chk1("midreset idle after release", mem_req, 1'b0);
    @(negedge CLOCK);
    #1;
    chk1 ("midreset regrant", mem_req, 1'b1);
    chk32("midreset regrant addr", mem_addr, 32'h40);

    // Data request withdrawn after grant still completes.
    do_reset();
    @(negedge CLOCK); d_req = 1; d_we = 0; d_addr = 32'h50;
    @(negedge CLOCK); d_req = 0;
    #1;
    chk1("drop still busy", mem_req, 1'b1);
    chk1("drop stall", stall, 1'b0);
    @(negedge CLOCK); mem_ack = 1; mem_rdata = 32'h1234;
    #1;
    chk1 ("drop d_ack", d_ack, 1'b1);
    chk32("drop d_rdata", d_rdata, 32'h1234);
    @(negedge CLOCK); mem_ack = 0;
    #1 chk1("drop idle", mem_req, 1'b0);

    // Random traffic against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 300 == 299) begin
        do_reset();
      end else begin
        @(negedge CLOCK);
        if_req    = ($urandom_range(0, 9) < 6);
        d_req     = ($urandom_range(0, 9) < 5);
        d_we      = $urandom_range(0, 1) == 1;
        if_addr   = $urandom;
        d_addr    = $urandom;
        d_wdata   = $urandom;
        mem_ack   = ($urandom_range(0, 9) < 5);
        mem_rdata = $urandom;
        #1;
        model_check();
        @(posedge CLOCK);
        model_edge();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
